// File: rtl/progmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous ROM.
// Each access is granted in IDLE, addresses the ROM in FETCH and returns data in RESP.
module progmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  output logic [DATA_W-1:0] m0_readdata,
  output logic [1:0]        m0_response,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [1:0]        m1_response,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_readdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;

  logic [1:0]        state;
  logic              grant;
  logic              last_grant;
  logic              err;
  logic              win;
  logic [ADDR_W-1:0] win_addr;
  logic              win_err;
  logic              hit0;
  logic              hit1;

  function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= DEPTH_L;
  endfunction

  // On a tie the master that was not served last wins; a lone requester always wins.
  always_comb begin
    win      = (m0_read && m1_read) ? ~last_grant : m1_read;
    win_addr = win ? m1_address : m0_address;
    win_err  = addr_oob(win_addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      err         <= 1'b0;
      rom_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_read || m1_read) begin
            grant       <= win;
            err         <= win_err;
            rom_address <= win_err ? '0 : win_addr;
            state       <= FETCH;
          end
        end
        FETCH: state <= RESP;
        RESP: begin
          // last_grant advances even if the requester dropped read mid-access.
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hit0 = (state == RESP) && !grant;
  assign hit1 = (state == RESP) &&  grant;

  assign m0_waitrequest = !hit0;
  assign m1_waitrequest = !hit1;
  assign m0_readdata    = (hit0 && !err) ? rom_readdata : '0;
  assign m1_readdata    = (hit1 && !err) ? rom_readdata : '0;
  assign m0_response    = (hit0 &&  err) ? RESP_SLVERR : RESP_OKAY;
  assign m1_response    = (hit1 &&  err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_progmem_arbiter.sv
// Bench for progmem_arbiter: directed scenarios plus random traffic, compared each
// cycle against a transaction-level model of grant timing and round-robin order.
module tb_progmem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 768;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] m0_address, m1_address, rom_address;
  logic              m0_read, m1_read;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, rom_readdata;
  logic [1:0]        m0_response, m1_response;
  logic              m0_waitrequest, m1_waitrequest;

  logic [DATA_W-1:0] rom_mem [1024];

  int    n_chk  = 0;
  int    n_pass = 0;
  longint cyc   = 0;

  // Reference model: one outstanding access, response two cycles after grant,
  // arbiter free again three cycles after grant.
  longint            resp_cyc = -10;
  longint            free_cyc = 0;
  int                who      = 0;
  int                last     = 1;
  logic [ADDR_W-1:0] paddr    = '0;

  progmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_readdata    (m0_readdata),
    .m0_response    (m0_response),
    .m0_waitrequest (m0_waitrequest),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_readdata    (m1_readdata),
    .m1_response    (m1_response),
    .m1_waitrequest (m1_waitrequest),
    .rom_address    (rom_address),
    .rom_readdata   (rom_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_readdata <= rom_mem[rom_address];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic step();
    logic              h0, h1, oob;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    h0  = rst_n && (cyc == resp_cyc) && (who == 0);
    h1  = rst_n && (cyc == resp_cyc) && (who == 1);
    oob = (int'(paddr) >= DEPTH);
    d   = oob ? '0 : rom_mem[paddr];
    check("m0_wait", m0_waitrequest, !h0);
    check("m1_wait", m1_waitrequest, !h1);
    check("m0_data", m0_readdata, h0 ? d : '0);
    check("m1_data", m1_readdata, h1 ? d : '0);
    check("m0_resp", m0_response, (h0 && oob) ? 2'b10 : 2'b00);
    check("m1_resp", m1_response, (h1 && oob) ? 2'b10 : 2'b00);
    if (!rst_n)
      check("rom_addr_rst", rom_address, '0);
    else if (cyc == resp_cyc - 1)
      check("rom_addr", rom_address, oob ? '0 : paddr);
    if (!rst_n) begin
      last     = 1;
      resp_cyc = -10;
      free_cyc = cyc + 1;
    end else if (cyc >= free_cyc && (m0_read || m1_read)) begin
      who      = (m0_read && m1_read) ? 1 - last : (m0_read ? 0 : 1);
      last     = who;
      paddr    = who ? m1_address : m0_address;
      resp_cyc = cyc + 2;
      free_cyc = cyc + 3;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
    rom_mem[5] = 32'hDEADBEEF;
    rst_n = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
    m0_address = '0; m1_address = '0;
    steps(2);
    rst_n = 1'b1;

    // Single read from m0.
    m0_read = 1'b1; m0_address = 10'h005;
    steps(3);
    m0_read = 1'b0;
    steps(2);

    // Tie straight after reset: m0 first, then m1.
    do_reset();
    m0_read = 1'b1; m0_address = 10'h001;
    m1_read = 1'b1; m1_address = 10'h002;
    steps(3);
    m0_read = 1'b0;
    steps(3);
    m1_read = 1'b0;
    steps(2);

    // Both requesters hold read continuously: alternating grants.
    m0_read = 1'b1; m0_address = 10'h010;
    m1_read = 1'b1; m1_address = 10'h020;
    steps(18);
    m0_read = 1'b0; m1_read = 1'b0;
    steps(2);

    // Out-of-range read from m1, plus an address change after grant.
    m1_read = 1'b1; m1_address = 10'h300;
    step();
    m1_address = 10'h004;
    steps(2);
    m1_read = 1'b0;
    steps(2);

    // Reset pulse while the m0 access sits in FETCH, then a fresh read.
    m0_read = 1'b1; m0_address = 10'h007;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; m0_read = 1'b0;
    steps(3);
    m0_read = 1'b1; m0_address = 10'h007;
    steps(3);
    m0_read = 1'b0;
    steps(2);

    // m1 drops read in FETCH; a tie afterwards goes to m0.
    m1_read = 1'b1; m1_address = 10'h009;
    step();
    m1_read = 1'b0;
    steps(3);
    m0_read = 1'b1; m0_address = 10'h00A;
    m1_read = 1'b1; m1_address = 10'h00B;
    steps(3);
    m0_read = 1'b0;
    steps(3);
    m1_read = 1'b0;
    steps(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      m0_read    = ($urandom_range(0, 3) != 0);
      m1_read    = ($urandom_range(0, 3) != 0);
      m0_address = ADDR_W'($urandom_range(0, 1023));
      m1_address = ADDR_W'($urandom_range(0, 1023));
      rst_n      = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1; m0_read = 1'b0; m1_read = 1'b0;
    steps(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
